sprite_mem_writer: RTL and testbench

Write-side engine for the sprite memory that feeds the SVGA pixel path. It accepts a load command (sprite element, base address, word count) and a stream of 12-bit RGB pixel words, and turns them into single-cycle writes on the sprite memory's write port. Optionally, writes are held off during the active video area so that sprites being displayed never tear. It sits between the host/loader logic and the sprite memory, in parallel with the display read path.

---
 rtl/sprite_mem_writer_pkg.sv | 31 +++
 rtl/sprite_mem_writer_cmd_check.sv | 34 +++
 rtl/sprite_mem_writer.sv | 159 +++++++++++++++
 tb/tb_sprite_mem_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mem_writer_pkg.sv
// Shared definitions for the sprite memory blocks.
// Holds the load-engine state encoding, default sprite geometry and the
// 12-bit RGB field layout used by the writer, the sprite memory and printRGB.
package sprite_mem_writer_pkg;

    // Load engine states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Default sprite geometry: three 20x20 sprites
    localparam int unsigned DefNumElements = 3;
    localparam int unsigned DefSpriteWords = 400;

    // RGB word layout, 4 bits per channel
    localparam int unsigned RgbRedMsb   = 11;
    localparam int unsigned RgbRedLsb   = 8;
    localparam int unsigned RgbGreenMsb = 7;
    localparam int unsigned RgbGreenLsb = 4;
    localparam int unsigned RgbBlueMsb  = 3;
    localparam int unsigned RgbBlueLsb  = 0;

    // Assemble an RGB word from its three 4-bit channels
    function automatic logic [11:0] rgb_pack(input logic [3:0] r, input logic [3:0] g,
                                             input logic [3:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/sprite_mem_writer_cmd_check.sv
// Combinational validator for sprite load commands.
// Ports:
//   element_i - target sprite index
//   base_i    - first word address inside the sprite
//   len_i     - number of words to write
//   valid_o   - 1 when the command is in range and non-empty
module sprite_cmd_check
    import sprite_mem_writer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = DefNumElements,
    parameter int unsigned SPRITE_WORDS = DefSpriteWords,
    parameter int unsigned ELEM_W       = 3,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic [ELEM_W-1:0] element_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              valid_o
);

    localparam logic [ELEM_W:0]   NumElems    = (ELEM_W+1)'(NUM_ELEMENTS);
    localparam logic [ADDR_W+1:0] SpriteWords = (ADDR_W+2)'(SPRITE_WORDS);

    // Two extra bits so base + len can never wrap
    logic [ADDR_W+1:0] end_addr;

    always_comb begin
        end_addr = {2'b00, base_i} + {1'b0, len_i};
        valid_o  = (len_i != '0) &&
                   ({1'b0, element_i} < NumElems) &&
                   (end_addr <= SpriteWords);
    end

endmodule

// File: rtl/sprite_mem_writer.sv
// Write-side engine for the sprite memory.
// Accepts a load command (element, base, length) and a pixel stream, and issues
// single-cycle writes to the sprite memory. With BLANK_ONLY set, pixels are only
// taken while video_enable is low so a displayed sprite never tears.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   video_enable             - active video area flag
//   cmd_valid/ready/element/base/len - load command handshake
//   abort                    - cancel current load
//   pix_valid/ready/data     - pixel stream handshake
//   mem_write_enable/element/address/datain - sprite memory write port
//   busy, done, error        - status (done pulses, error is sticky)
module sprite_mem_writer
    import sprite_mem_writer_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = DefNumElements,
    parameter int unsigned ELEM_W       = 3,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned SPRITE_WORDS = DefSpriteWords,
    parameter int unsigned BLANK_ONLY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ELEM_W-1:0] cmd_element,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              abort,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              mem_write_enable,
    output logic [ELEM_W-1:0] mem_element,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic BlankOnly = (BLANK_ONLY != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic              we_q, we_d;
    logic [ELEM_W-1:0] mem_elem_q, mem_elem_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cmd_ok;

    sprite_cmd_check #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .SPRITE_WORDS (SPRITE_WORDS),
        .ELEM_W       (ELEM_W),
        .ADDR_W       (ADDR_W)
    ) u_cmd_check (
        .element_i (cmd_element),
        .base_i    (cmd_base),
        .len_i     (cmd_len),
        .valid_o   (cmd_ok)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        elem_d      = elem_q;
        we_d        = 1'b0;
        mem_elem_d  = mem_elem_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        done_d      = 1'b0;
        error_d     = error_q;
        cmd_ready   = 1'b0;
        pix_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_ok) begin
                        error_d     = 1'b0;
                        elem_d      = cmd_element;
                        addr_d      = cmd_base;
                        remaining_d = cmd_len;
                        state_d     = StWrite;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                // Abort blocks the transfer in the same cycle
                pix_ready = !abort && !(BlankOnly && video_enable);
                if (abort) begin
                    state_d = StIdle;
                end else if (pix_valid && pix_ready) begin
                    we_d        = 1'b1;
                    mem_elem_d  = elem_q;
                    mem_addr_d  = addr_q;
                    mem_data_d  = pix_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // done is registered, so it lands one cycle after the last write
                state_d = StIdle;
                done_d  = !abort;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            elem_q      <= '0;
            we_q        <= 1'b0;
            mem_elem_q  <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            elem_q      <= elem_d;
            we_q        <= we_d;
            mem_elem_q  <= mem_elem_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_write_enable = we_q;
    assign mem_element      = mem_elem_q;
    assign mem_address      = mem_addr_q;
    assign mem_datain       = mem_data_q;
    assign done             = done_q;
    assign error            = error_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_mem_writer.sv
module tb_sprite_mem_writer;

    localparam int ELEM_W = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              video_enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ELEM_W-1:0] cmd_element;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic              abort;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              mem_write_enable;
    logic [ELEM_W-1:0] mem_element;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_datain;
    logic              busy;
    logic              done;
    logic              error;

    sprite_mem_writer #(
        .NUM_ELEMENTS (3),
        .ELEM_W       (ELEM_W),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .SPRITE_WORDS (400),
        .BLANK_ONLY   (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .video_enable     (video_enable),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_element      (cmd_element),
        .cmd_base         (cmd_base),
        .cmd_len          (cmd_len),
        .abort            (abort),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_data         (pix_data),
        .mem_write_enable (mem_write_enable),
        .mem_element      (mem_element),
        .mem_address      (mem_address),
        .mem_datain       (mem_datain),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int elem;
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    always @(negedge clk) begin
        wr_t w;
        if (mem_write_enable) begin
            w.elem = int'(mem_element);
            w.addr = int'(mem_address);
            w.data = int'(mem_datain);
            w.cyc  = cyc;
            wq.push_back(w);
        end
        if (done) dq.push_back(cyc);
    end

    int n_pass  = 0;
    int n_total = 0;
    int pix_buf[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int e, input int b, input int l);
        cmd_element = ELEM_W'(e);
        cmd_base    = ADDR_W'(b);
        cmd_len     = (ADDR_W+1)'(l);
        cmd_valid   = 1'b1;
        tick();
        cmd_valid   = 1'b0;
    endtask

    // Push n words from pix_buf, retrying while the engine stalls
    task automatic send_pixels(input int n);
        int   i = 0;
        int   guard = 0;
        logic r;
        while (i < n && guard < 100) begin
            pix_valid = 1'b1;
            pix_data  = DATA_W'(pix_buf[i]);
            #1;
            r = pix_ready;
            tick();
            if (r) i++;
            guard++;
        end
        pix_valid = 1'b0;
        chk("pixels accepted before timeout", i, n);
    endtask

    typedef struct {
        int elem;
        int base;
        int len;
        int exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 4, 0};
        vecs[1] = '{1, 398, 3, 1};
        vecs[2] = '{1, 398, 2, 0};
        vecs[3] = '{3, 0, 1, 1};
        vecs[4] = '{0, 0, 0, 1};
        vecs[5] = '{2, 399, 1, 0};
        vecs[6] = '{7, 0, 1, 1};
        vecs[7] = '{0, 0, 400, 0};
        vecs[8] = '{0, 1, 400, 1};
        vecs[9] = '{0, 1023, 2047, 1};

        reset = 1'b1;
        video_enable = 1'b0;
        cmd_valid = 1'b0;
        cmd_element = '0;
        cmd_base = '0;
        cmd_len = '0;
        abort = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;

        // Reset state
        tick();
        tick();
        chk("reset we", 32'(mem_write_enable), 0);
        chk("reset addr", 32'(mem_address), 0);
        chk("reset done", 32'(done), 0);
        chk("reset error", 32'(error), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset cmd_ready", 32'(cmd_ready), 1);
        chk("reset pix_ready", 32'(pix_ready), 0);
        reset = 1'b0;
        tick();

        // Command validation table; accepted loads are aborted straight away
        for (int i = 0; i < 10; i++) begin
            cmd_element = ELEM_W'(vecs[i].elem);
            cmd_base    = ADDR_W'(vecs[i].base);
            cmd_len     = (ADDR_W+1)'(vecs[i].len);
            cmd_valid   = 1'b1;
            #1;
            chk("vec cmd_ready", 32'(cmd_ready), 1);
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("vec%0d error", i), 32'(error), vecs[i].exp_err);
            chk($sformatf("vec%0d busy", i), 32'(busy), 1 - vecs[i].exp_err);
            if (vecs[i].exp_err == 0) begin
                abort = 1'b1;
                #1;
                chk("vec abort pix_ready", 32'(pix_ready), 0);
                tick();
                abort = 1'b0;
                chk("vec busy after abort", 32'(busy), 0);
            end
        end
        tick();
        chk("table writes", wq.size(), 0);
        chk("table dones", dq.size(), 0);

        // Basic four-word burst
        wq.delete();
        dq.delete();
        send_cmd(1, 0, 4);
        chk("burst busy", 32'(busy), 1);
        chk("burst cmd_ready", 32'(cmd_ready), 0);
        pix_buf[0] = 'hF00;
        pix_buf[1] = 'h0F0;
        pix_buf[2] = 'h00F;
        pix_buf[3] = 'hFFF;
        send_pixels(4);
        repeat (3) tick();
        chk("burst writes", wq.size(), 4);
        for (int k = 0; k < wq.size() && k < 4; k++) begin
            chk($sformatf("burst addr%0d", k), wq[k].addr, k);
            chk($sformatf("burst data%0d", k), wq[k].data, pix_buf[k]);
            chk($sformatf("burst elem%0d", k), wq[k].elem, 1);
            chk($sformatf("burst cyc%0d", k), wq[k].cyc, wq[0].cyc + k);
        end
        chk("burst done count", dq.size(), 1);
        if (dq.size() == 1 && wq.size() == 4)
            chk("burst done timing", dq[0], wq[3].cyc + 1);
        chk("burst busy after", 32'(busy), 0);

        // Overflowing command then a fitting one at the top of the sprite
        wq.delete();
        dq.delete();
        send_cmd(0, 398, 3);
        chk("ovf error", 32'(error), 1);
        chk("ovf cmd_ready", 32'(cmd_ready), 1);
        chk("ovf busy", 32'(busy), 0);
        send_cmd(0, 398, 2);
        chk("fit error cleared", 32'(error), 0);
        pix_buf[0] = 'h123;
        pix_buf[1] = 'h456;
        send_pixels(2);
        repeat (3) tick();
        chk("fit writes", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("fit addr0", wq[0].addr, 398);
            chk("fit addr1", wq[1].addr, 399);
            chk("fit data1", wq[1].data, 'h456);
        end
        chk("fit done count", dq.size(), 1);

        // Video-active stall mid-burst
        wq.delete();
        dq.delete();
        send_cmd(2, 10, 5);
        pix_valid = 1'b1;
        pix_data  = 12'hA00;
        tick();
        pix_data  = 12'hA01;
        tick();
        video_enable = 1'b1;
        pix_data = 12'hA02;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall pix_ready", 32'(pix_ready), 0);
            tick();
        end
        video_enable = 1'b0;
        pix_buf[0] = 'hA02;
        pix_buf[1] = 'hA03;
        pix_buf[2] = 'hA04;
        send_pixels(3);
        repeat (3) tick();
        chk("stall writes", wq.size(), 5);
        for (int k = 0; k < wq.size() && k < 5; k++) begin
            chk($sformatf("stall addr%0d", k), wq[k].addr, 10 + k);
            chk($sformatf("stall data%0d", k), wq[k].data, 'hA00 + k);
        end
        if (wq.size() == 5) chk("stall gap", wq[2].cyc - wq[1].cyc, 4);
        chk("stall done count", dq.size(), 1);

        // Abort after two of six words, then an immediate new command
        wq.delete();
        dq.delete();
        send_cmd(0, 100, 6);
        pix_buf[0] = 'h111;
        pix_buf[1] = 'h222;
        send_pixels(2);
        pix_valid = 1'b1;
        pix_data  = 12'hBAD;
        abort     = 1'b1;
        #1;
        chk("abort pix_ready", 32'(pix_ready), 0);
        tick();
        abort = 1'b0;
        pix_valid = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort cmd_ready", 32'(cmd_ready), 1);
        send_cmd(1, 5, 1);
        chk("post-abort busy", 32'(busy), 1);
        pix_buf[0] = 'h777;
        send_pixels(1);
        repeat (3) tick();
        chk("abort writes", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("abort addr1", wq[1].addr, 101);
            chk("abort next addr", wq[2].addr, 5);
            chk("abort next elem", wq[2].elem, 1);
            chk("abort next data", wq[2].data, 'h777);
        end
        chk("abort done count", dq.size(), 1);
        chk("abort error", 32'(error), 0);

        // Reset in the middle of a burst
        send_cmd(2, 0, 5);
        pix_buf[0] = 'h0AB;
        pix_buf[1] = 'h0CD;
        send_pixels(2);
        pix_valid = 1'b1;
        pix_data  = 12'h0EF;
        #1;
        reset = 1'b1;
        #1;
        chk("rst we", 32'(mem_write_enable), 0);
        chk("rst elem", 32'(mem_element), 0);
        chk("rst addr", 32'(mem_address), 0);
        chk("rst data", 32'(mem_datain), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst pix_ready", 32'(pix_ready), 0);
        chk("rst cmd_ready", 32'(cmd_ready), 1);
        tick();
        pix_valid = 1'b0;
        reset = 1'b0;
        tick();
        wq.delete();
        dq.delete();
        send_cmd(0, 7, 1);
        pix_buf[0] = 'h5A5;
        send_pixels(1);
        repeat (3) tick();
        chk("post-rst writes", wq.size(), 1);
        chk("post-rst done count", dq.size(), 1);
        if (wq.size() == 1 && dq.size() == 1) begin
            chk("post-rst addr", wq[0].addr, 7);
            chk("post-rst data", wq[0].data, 'h5A5);
            chk("post-rst done timing", dq[0], wq[0].cyc + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
